// File: rtl/usb_tx_pktbuf.sv
`default_nettype none
// ============================================================================
// Module   : usb_tx_pktbuf
// Purpose  : Four-region TX packet buffer. It accepts the addressed word
//            stream from the command decoder and holds each region until it
//            is closed. It then drains each closed region as one framed
//            packet toward the USB slave-FIFO writer, using a valid/ready
//            handshake.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   mclk        in   main clock (48 MHz)
//   rst         in   asynchronous active-high reset
//   tx_vd       in   write strobe
//   tx_addr     in   {region[1:0], low address}
//   tx_data     in   write data
//   tx_eop      in   closes the region addressed by tx_addr MSBs
//   out_vd      out  output word valid
//   out_rdy     in   downstream accepts the word
//   out_data    out  output word
//   out_sop     out  first word of packet (qualified by out_vd)
//   out_eop     out  last word of packet (qualified by out_vd)
//   out_region  out  region being drained, stable for the whole packet
//   ovf         out  sticky overflow flag
//   ovf_clr     in   clears ovf (a same-cycle set wins)
// ============================================================================
module usb_tx_pktbuf #(
    parameter int P_DATA_NBIT = 16,
    parameter int P_ADDR_NBIT = 8
) (
    input  logic                   mclk,
    input  logic                   rst,
    input  logic                   tx_vd,
    input  logic [P_ADDR_NBIT+1:0] tx_addr,
    input  logic [P_DATA_NBIT-1:0] tx_data,
    input  logic                   tx_eop,
    output logic                   out_vd,
    input  logic                   out_rdy,
    output logic [P_DATA_NBIT-1:0] out_data,
    output logic                   out_sop,
    output logic                   out_eop,
    output logic [1:0]             out_region,
    output logic                   ovf,
    input  logic                   ovf_clr
);

    localparam int                   c_LEN_NBIT  = P_ADDR_NBIT + 1;
    localparam int                   c_MEM_DEPTH = 4 << P_ADDR_NBIT;
    localparam logic [c_LEN_NBIT-1:0] c_ONE      = c_LEN_NBIT'(1);

    typedef enum logic [1:0] {
        RG_FREE  = 2'd0,
        RG_FILL  = 2'd1,
        RG_READY = 2'd2,
        RG_BUSY  = 2'd3
    } region_state_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_SEND = 2'd2
    } drain_state_t;

    // ------------------------------------------------------------------
    // Region bookkeeping
    // ------------------------------------------------------------------
    region_state_t           r_rg_state [4];
    logic [c_LEN_NBIT-1:0]   r_rg_len   [4];
    logic                    r_pang_older;   // region 11 completed before region 10
    logic                    r_ovf;

    logic [1:0]              w_wr_rg;
    logic [P_ADDR_NBIT-1:0]  w_wr_low;
    region_state_t           w_wr_st;
    logic                    w_open;
    logic                    w_wr_en;
    logic                    w_close;
    logic                    w_ovf_set;

    assign w_wr_rg   = tx_addr[P_ADDR_NBIT+1:P_ADDR_NBIT];
    assign w_wr_low  = tx_addr[P_ADDR_NBIT-1:0];
    assign w_wr_st   = r_rg_state[w_wr_rg];
    assign w_open    = (w_wr_st == RG_FREE) || (w_wr_st == RG_FILL);
    assign w_wr_en   = tx_vd & w_open;
    // An eop alone only closes a region that already holds data.
    assign w_close   = tx_eop & ((w_wr_st == RG_FILL) | ((w_wr_st == RG_FREE) & tx_vd));
    assign w_ovf_set = (tx_vd | tx_eop) & ~w_open;

    // ------------------------------------------------------------------
    // Drain control signals
    // ------------------------------------------------------------------
    drain_state_t            r_state;
    drain_state_t            w_state_nxt;
    logic [1:0]              r_out_region;
    logic [c_LEN_NBIT-1:0]   r_rd_cnt;       // words issued to the memory so far
    logic                    w_grant;
    logic                    w_rd_en;
    logic                    w_pkt_done;
    logic [c_LEN_NBIT-1:0]   w_issue_idx;
    logic [c_LEN_NBIT-1:0]   w_cur_len;
    logic [3:0]              w_rdy;
    logic                    w_any_rdy;
    logic [1:0]              w_pick;

    assign w_cur_len = r_rg_len[r_out_region];

    always_comb begin
        w_rdy = '0;
        for (int i = 0; i < 4; i++) begin
            w_rdy[i] = (r_rg_state[i] == RG_READY);
        end
    end

    assign w_any_rdy = |w_rdy;

    always_comb begin
        w_pick = 2'd0;
        if (w_rdy[0]) begin
            w_pick = 2'd0;
        end else if (w_rdy[2] && w_rdy[3]) begin
            w_pick = r_pang_older ? 2'd3 : 2'd2;
        end else if (w_rdy[2]) begin
            w_pick = 2'd2;
        end else if (w_rdy[3]) begin
            w_pick = 2'd3;
        end else if (w_rdy[1]) begin
            w_pick = 2'd1;
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline: memory output register (stage 1) feeding a 2-entry
    // skid FIFO whose head drives the outputs.
    // ------------------------------------------------------------------
    logic [P_DATA_NBIT-1:0]            r_s1_data;
    logic                              r_s1_vd;
    logic                              r_s1_sop;
    logic                              r_s1_eop;
    logic [1:0][P_DATA_NBIT-1:0]       r_fq_data;
    logic [1:0]                        r_fq_sop;
    logic [1:0]                        r_fq_eop;
    logic                              r_fq_wp;
    logic                              r_fq_rp;
    logic [1:0]                        r_fq_cnt;
    logic [1:0]                        w_fq_cnt_nxt;
    logic [1:0]                        w_fill;
    logic [1:0]                        w_fill_after;
    logic                              w_room;
    logic                              w_pop;
    logic                              w_head_eop;
    logic [P_ADDR_NBIT+1:0]            w_rd_addr;

    assign out_vd     = (r_fq_cnt != 2'd0);
    assign w_pop      = out_vd & out_rdy;
    assign w_head_eop = r_fq_eop[r_fq_rp];

    // Words in flight (stage 1) plus words queued must never exceed two once
    // the head is popped. This keeps one word per cycle while out_rdy is held
    // high, and it never overruns the skid FIFO when out_rdy drops.
    assign w_fill       = r_fq_cnt + {1'b0, r_s1_vd};
    assign w_fill_after = w_fill - {1'b0, w_pop};
    assign w_room       = (w_fill_after < 2'd2);
    assign w_fq_cnt_nxt = r_fq_cnt + {1'b0, r_s1_vd} - {1'b0, w_pop};
    assign w_rd_addr    = {r_out_region, w_issue_idx[P_ADDR_NBIT-1:0]};

    // ------------------------------------------------------------------
    // Drain FSM
    // ------------------------------------------------------------------
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_rd_en     = 1'b0;
        w_pkt_done  = 1'b0;
        w_issue_idx = r_rd_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_any_rdy) begin
                    w_grant     = 1'b1;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_rd_en     = 1'b1;
                w_issue_idx = '0;
                w_state_nxt = S_SEND;
            end
            S_SEND: begin
                w_rd_en = (r_rd_cnt != w_cur_len) && w_room;
                if (w_pop && w_head_eop) begin
                    w_pkt_done  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Region state, lengths, completion order and overflow
    // ------------------------------------------------------------------
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                r_rg_state[i] <= RG_FREE;
                r_rg_len[i]   <= '0;
            end
            r_pang_older <= 1'b0;
            r_ovf        <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_grant && (w_pick == 2'(i))) begin
                    r_rg_state[i] <= RG_BUSY;
                end else if (w_pkt_done && (r_out_region == 2'(i))) begin
                    r_rg_state[i] <= RG_FREE;
                end else if (w_wr_rg == 2'(i)) begin
                    if (w_wr_en) begin
                        r_rg_len[i]   <= c_LEN_NBIT'(w_wr_low) + c_ONE;
                        r_rg_state[i] <= tx_eop ? RG_READY : RG_FILL;
                    end else if (w_close) begin
                        r_rg_state[i] <= RG_READY;
                    end
                end
            end
            // Only one region can close per cycle. When 10 closes while 11 is
            // still waiting, 11 is the older one. A close of 11 always makes
            // 11 the younger, or leaves the flag irrelevant until 10 closes.
            if (w_close && (w_wr_rg == 2'd2)) begin
                r_pang_older <= (r_rg_state[3] == RG_READY);
            end else if (w_close && (w_wr_rg == 2'd3)) begin
                r_pang_older <= 1'b0;
            end
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Packet memory: one write port, one registered read port
    // ------------------------------------------------------------------
    logic [P_DATA_NBIT-1:0] r_mem [0:c_MEM_DEPTH-1];

    always_ff @(posedge mclk) begin
        if (w_wr_en) begin
            r_mem[tx_addr] <= tx_data;
        end
        if (w_rd_en) begin
            r_s1_data <= r_mem[w_rd_addr];
        end
    end

    // ------------------------------------------------------------------
    // Read issue, stage-1 flags and skid FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            r_out_region <= 2'd0;
            r_rd_cnt     <= '0;
            r_s1_vd      <= 1'b0;
            r_s1_sop     <= 1'b0;
            r_s1_eop     <= 1'b0;
            r_fq_data    <= '0;
            r_fq_sop     <= '0;
            r_fq_eop     <= '0;
            r_fq_wp      <= 1'b0;
            r_fq_rp      <= 1'b0;
            r_fq_cnt     <= 2'd0;
        end else begin
            if (w_grant) begin
                r_out_region <= w_pick;
            end
            r_s1_vd <= w_rd_en;
            if (w_rd_en) begin
                r_rd_cnt <= w_issue_idx + c_ONE;
                r_s1_sop <= (w_issue_idx == '0);
                r_s1_eop <= ((w_issue_idx + c_ONE) == w_cur_len);
            end
            if (r_s1_vd) begin
                r_fq_data[r_fq_wp] <= r_s1_data;
                r_fq_sop[r_fq_wp]  <= r_s1_sop;
                r_fq_eop[r_fq_wp]  <= r_s1_eop;
                r_fq_wp            <= ~r_fq_wp;
            end
            if (w_pop) begin
                r_fq_rp <= ~r_fq_rp;
            end
            r_fq_cnt <= w_fq_cnt_nxt;
        end
    end

    assign out_data   = r_fq_data[r_fq_rp];
    assign out_sop    = out_vd & r_fq_sop[r_fq_rp];
    assign out_eop    = out_vd & w_head_eop;
    assign out_region = r_out_region;
    assign ovf        = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_usb_tx_pktbuf.sv
`default_nettype none
// ============================================================================
// Module   : tb_usb_tx_pktbuf
// Purpose  : Directed self-checking bench for usb_tx_pktbuf. Expected output
//            words are queued when the stimulus is written, and a negedge
//            monitor pops and compares them on every transfer. The monitor
//            also checks that output words hold steady while stalled.
// Revision : 1.0 - initial release
// ============================================================================
module tb_usb_tx_pktbuf;

    typedef struct packed {
        logic [1:0]  region;
        logic        sop;
        logic        eop;
        logic [15:0] data;
    } word_t;

    logic        mclk = 1'b0;
    logic        rst;
    logic        tx_vd;
    logic [9:0]  tx_addr;
    logic [15:0] tx_data;
    logic        tx_eop;
    logic        out_vd;
    logic        out_rdy;
    logic [15:0] out_data;
    logic        out_sop;
    logic        out_eop;
    logic [1:0]  out_region;
    logic        ovf;
    logic        ovf_clr;

    word_t       q[$];
    int          total  = 0;
    int          bad    = 0;
    int          n_xfer = 0;
    logic        rdy_rand = 1'b0;
    logic        rdy_val  = 1'b1;

    usb_tx_pktbuf #(
        .P_DATA_NBIT (16),
        .P_ADDR_NBIT (8)
    ) dut (
        .mclk       (mclk),
        .rst        (rst),
        .tx_vd      (tx_vd),
        .tx_addr    (tx_addr),
        .tx_data    (tx_data),
        .tx_eop     (tx_eop),
        .out_vd     (out_vd),
        .out_rdy    (out_rdy),
        .out_data   (out_data),
        .out_sop    (out_sop),
        .out_eop    (out_eop),
        .out_region (out_region),
        .ovf        (ovf),
        .ovf_clr    (ovf_clr)
    );

    initial forever #10 mclk = ~mclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // Downstream ready: fixed level or random toggling.
    initial begin
        out_rdy = 1'b0;
        forever begin
            @(posedge mclk);
            #1;
            out_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
        end
    end

    function automatic logic [15:0] pat(input int rg, input int a, input int seed);
        return 16'(seed * 4099 + rg * 1031 + a * 7 + 32'h1234);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int rg, input int a, input logic [15:0] d, input logic eop);
        tx_vd   = 1'b1;
        tx_eop  = eop;
        tx_addr = 10'((rg << 8) | a);
        tx_data = d;
        @(posedge mclk);
        #1;
        tx_vd  = 1'b0;
        tx_eop = 1'b0;
    endtask

    task automatic eop_only(input int rg);
        tx_eop  = 1'b1;
        tx_addr = 10'(rg << 8);
        @(posedge mclk);
        #1;
        tx_eop = 1'b0;
    endtask

    task automatic fill(input int rg, input int len, input int seed, input logic close);
        for (int a = 0; a < len; a++) begin
            wr(rg, a, pat(rg, a, seed), close && (a == len - 1));
        end
    endtask

    task automatic expect_pkt(input int rg, input int len, input int seed);
        word_t w;
        for (int a = 0; a < len; a++) begin
            w = {2'(rg), 1'(a == 0), 1'(a == len - 1), pat(rg, a, seed)};
            q.push_back(w);
        end
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((q.size() != 0 || out_vd) && n < budget) begin
            @(posedge mclk);
            #1;
            n++;
        end
        total++;
        assert (q.size() == 0) else begin
            bad++;
            $error("FAIL %s: words left=%0d expected=0", tag, q.size());
        end
    endtask

    // Output monitor / scoreboard.
    word_t obs_w;
    word_t prev_w;
    word_t exp_w;
    logic  prev_stall = 1'b0;

    always @(negedge mclk) begin
        obs_w = {out_region, out_sop, out_eop, out_data};
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                total++;
                assert (out_vd === 1'b1 && obs_w === prev_w) else begin
                    bad++;
                    $error("FAIL hold: observed vd=%0b word=%h expected vd=1 word=%h", out_vd, obs_w, prev_w);
                end
            end
            if (out_vd && out_rdy) begin
                n_xfer++;
                total++;
                assert (q.size() != 0) else begin
                    bad++;
                    $error("FAIL unexpected: observed word=%h expected none", obs_w);
                end
                if (q.size() != 0) begin
                    exp_w = q.pop_front();
                    total++;
                    assert (obs_w === exp_w) else begin
                        bad++;
                        $error("FAIL word: observed=%h expected=%h", obs_w, exp_w);
                    end
                end
            end
            prev_stall = out_vd && !out_rdy;
            prev_w     = obs_w;
        end
    end

    initial begin
        int   base;
        int   n;
        logic seen;

        rst     = 1'b1;
        tx_vd   = 1'b0;
        tx_eop  = 1'b0;
        tx_addr = '0;
        tx_data = '0;
        ovf_clr = 1'b0;
        repeat (3) @(negedge mclk);

        // Reset state
        chk("rst_out_vd", out_vd, 0);
        chk("rst_out_sop", out_sop, 0);
        chk("rst_out_eop", out_eop, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_region", out_region, 0);
        chk("rst_ovf", ovf, 0);
        rst = 1'b0;
        @(posedge mclk);
        #1;

        // 1: handshake packet, first valid three cycles after tx_eop
        expect_pkt(0, 4, 1);
        fill(0, 4, 1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge mclk);
            chk("t1_latency_low", out_vd, 0);
        end
        @(negedge mclk);
        chk("t1_latency_high", out_vd, 1);
        chk("t1_first_sop", out_sop, 1);
        @(posedge mclk);
        #1;
        wait_drain("t1_drain", 50);

        // 2: 256-word ADC frame closed by a bare tx_eop, random backpressure
        rdy_rand = 1'b1;
        expect_pkt(2, 256, 2);
        fill(2, 256, 2, 1'b0);
        eop_only(2);
        wait_drain("t2_drain", 4000);
        rdy_rand = 1'b0;
        rdy_val  = 1'b1;

        // 3: ping-pong ordering with handshake priority
        expect_pkt(3, 40, 3);
        fill(3, 40, 3, 1'b1);
        fill(2, 4, 4, 1'b1);
        fill(0, 3, 5, 1'b1);
        expect_pkt(0, 3, 5);
        expect_pkt(2, 4, 4);
        wait_drain("t3_drain", 400);

        // 4: overflow, set-wins-over-clear, sticky, then clear
        rdy_val = 1'b0;
        expect_pkt(2, 4, 6);
        fill(2, 4, 6, 1'b1);
        chk("t4_ovf_before", ovf, 0);
        wr(2, 0, 16'hDEAD, 1'b0);
        chk("t4_ovf_set", ovf, 1);
        ovf_clr = 1'b1;
        wr(2, 1, 16'hBEEF, 1'b0);
        ovf_clr = 1'b0;
        chk("t4_set_wins", ovf, 1);
        rdy_val = 1'b1;
        wait_drain("t4_drain", 50);
        chk("t4_ovf_sticky", ovf, 1);
        ovf_clr = 1'b1;
        @(posedge mclk);
        #1;
        ovf_clr = 1'b0;
        chk("t4_ovf_cleared", ovf, 0);

        // 5: reset at word 100 of a 256-word packet
        expect_pkt(3, 256, 7);
        base = n_xfer;
        fill(3, 256, 7, 1'b1);
        n = 0;
        while ((n_xfer - base) < 100 && n < 1000) begin
            @(negedge mclk);
            n++;
        end
        chk("t5_reached_word100", 32'((n_xfer - base) >= 100), 1);
        rst = 1'b1;
        #1;
        chk("t5_rst_out_vd", out_vd, 0);
        chk("t5_rst_out_eop", out_eop, 0);
        chk("t5_rst_out_sop", out_sop, 0);
        chk("t5_rst_out_data", out_data, 0);
        chk("t5_rst_out_region", out_region, 0);
        q.delete();
        repeat (2) @(negedge mclk);
        rst = 1'b0;
        @(posedge mclk);
        #1;
        expect_pkt(0, 5, 8);
        fill(0, 5, 8, 1'b1);
        wait_drain("t5_after_rst", 50);
        expect_pkt(3, 2, 9);
        fill(3, 2, 9, 1'b1);
        wait_drain("t5_region11_free", 50);
        chk("t5_ovf_clear", ovf, 0);

        // 6: one-word packet, and bare tx_eop to a FREE region
        expect_pkt(0, 1, 10);
        fill(0, 1, 10, 1'b1);
        wait_drain("t6_one_word", 50);
        eop_only(1);
        seen = 1'b0;
        repeat (12) begin
            @(negedge mclk);
            if (out_vd) seen = 1'b1;
        end
        chk("t6_eop_free_silent", seen, 0);
        chk("t6_ovf_clear", ovf, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
